// File: rtl/id_ex_stage_reg.sv
// Purpose : ID/EX pipeline register with load-use hazard detection, branch flush, stall hold and bubble counter.
// Latency : one cycle from id_* inputs to ex_* outputs; stall_o is combinational (same cycle).
// Backpres: ex_stall_i holds every ex_* output; a load-use hazard raises stall_o and injects one bubble into EX.
// Ports   : clk_i/rst_n_i (async active-low); id_* decoded instruction and forwarded operands;
//           flush_i kills the ID instruction; ex_stall_i freezes this register; ex_* registered EX copy;
//           stall_o holds PC and IF/ID; bubble_cnt_o saturating count of load-use bubbles.
module id_ex_stage_reg #(
  parameter int ALU_OP_W = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                id_valid_i,
  input  logic [31:0]         id_pc_i,
  input  logic [31:0]         id_pc_plus4_i,
  input  logic [4:0]          id_rs1_addr_i,
  input  logic [4:0]          id_rs2_addr_i,
  input  logic                id_rs1_used_i,
  input  logic                id_rs2_used_i,
  input  logic [31:0]         id_rs1_data_i,
  input  logic [31:0]         id_rs2_data_i,
  input  logic [31:0]         id_imm_i,
  input  logic [4:0]          id_rd_addr_i,
  input  logic                id_reg_wr_sig_i,
  input  logic [1:0]          id_data_dest_i,
  input  logic                id_mem_wr_i,
  input  logic [ALU_OP_W-1:0] id_alu_op_i,
  input  logic                flush_i,
  input  logic                ex_stall_i,
  output logic                ex_valid_o,
  output logic [31:0]         ex_pc_o,
  output logic [31:0]         ex_pc_plus4_o,
  output logic [31:0]         ex_rs1_data_o,
  output logic [31:0]         ex_rs2_data_o,
  output logic [31:0]         ex_imm_o,
  output logic [4:0]          ex_rd_addr_o,
  output logic                ex_reg_wr_sig_o,
  output logic [1:0]          ex_data_dest_o,
  output logic                ex_mem_wr_o,
  output logic [ALU_OP_W-1:0] ex_alu_op_o,
  output logic                stall_o,
  output logic [CNT_W-1:0]    bubble_cnt_o
);

  // Writeback-source encoding shared with decode: 0 = ALU, 1 = MEM (load), 2 = PC.
  localparam logic [1:0] DEST_MEM = 2'd1;

  logic                r_valid;
  logic [31:0]         r_pc;
  logic [31:0]         r_pc_plus4;
  logic [31:0]         r_rs1_data;
  logic [31:0]         r_rs2_data;
  logic [31:0]         r_imm;
  logic [4:0]          r_rd_addr;
  logic                r_reg_wr;
  logic [1:0]          r_data_dest;
  logic                r_mem_wr;
  logic [ALU_OP_W-1:0] r_alu_op;
  logic [CNT_W-1:0]    r_bubble_cnt;

  logic w_ex_is_load;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_hazard;
  logic w_cnt_sat;

  // A load in EX only produces its data after MEM, so an ID consumer of its rd
  // must wait one cycle; x0 is never a real destination.
  assign w_ex_is_load = r_valid & r_reg_wr & (r_rd_addr != 5'd0) & (r_data_dest == DEST_MEM);
  assign w_rs1_hit    = id_rs1_used_i & (id_rs1_addr_i == r_rd_addr);
  assign w_rs2_hit    = id_rs2_used_i & (id_rs2_addr_i == r_rd_addr);
  assign w_hazard     = w_ex_is_load & id_valid_i & (w_rs1_hit | w_rs2_hit);
  assign w_cnt_sat    = &r_bubble_cnt;

  // A flushed ID instruction is dead, so it must not hold the front end; the
  // rst_n_i term keeps stall_o low while reset is asserted.
  assign stall_o = rst_n_i & (ex_stall_i | (w_hazard & ~flush_i));

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid      <= 1'b0;
      r_pc         <= '0;
      r_pc_plus4   <= '0;
      r_rs1_data   <= '0;
      r_rs2_data   <= '0;
      r_imm        <= '0;
      r_rd_addr    <= '0;
      r_reg_wr     <= 1'b0;
      r_data_dest  <= '0;
      r_mem_wr     <= 1'b0;
      r_alu_op     <= '0;
      r_bubble_cnt <= '0;
    end else if (flush_i) begin
      // Data fields are don't-care for a killed entry and simply hold.
      r_valid  <= 1'b0;
      r_reg_wr <= 1'b0;
      r_mem_wr <= 1'b0;
    end else if (ex_stall_i) begin
      // Downstream full: keep the current EX entry intact.
    end else if (w_hazard) begin
      r_valid  <= 1'b0;
      r_reg_wr <= 1'b0;
      r_mem_wr <= 1'b0;
      if (!w_cnt_sat) begin
        r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
      end
    end else begin
      r_valid     <= id_valid_i;
      r_pc        <= id_pc_i;
      r_pc_plus4  <= id_pc_plus4_i;
      r_rs1_data  <= id_rs1_data_i;
      r_rs2_data  <= id_rs2_data_i;
      r_imm       <= id_imm_i;
      r_rd_addr   <= id_rd_addr_i;
      r_reg_wr    <= id_reg_wr_sig_i & id_valid_i;
      r_data_dest <= id_data_dest_i;
      r_mem_wr    <= id_mem_wr_i & id_valid_i;
      r_alu_op    <= id_alu_op_i;
    end
  end

  assign ex_valid_o      = r_valid;
  assign ex_pc_o         = r_pc;
  assign ex_pc_plus4_o   = r_pc_plus4;
  assign ex_rs1_data_o   = r_rs1_data;
  assign ex_rs2_data_o   = r_rs2_data;
  assign ex_imm_o        = r_imm;
  assign ex_rd_addr_o    = r_rd_addr;
  assign ex_reg_wr_sig_o = r_reg_wr;
  assign ex_data_dest_o  = r_data_dest;
  assign ex_mem_wr_o     = r_mem_wr;
  assign ex_alu_op_o     = r_alu_op;
  assign bubble_cnt_o    = r_bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Purpose : self-checking bench for id_ex_stage_reg (narrow bubble counter to reach saturation quickly).
// Latency : expects ex_* one edge after ID inputs, stall_o in the same cycle.
// Backpres: exercises ex_stall_i hold, load-use bubbles and flush priority.
module tb_id_ex_stage_reg;

  localparam int AW = 4;
  localparam int CW = 2;
  localparam logic [1:0] D_ALU = 2'd0;
  localparam logic [1:0] D_MEM = 2'd1;
  localparam logic [1:0] D_PC  = 2'd2;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc, pc4;
    logic [4:0]    rs1a, rs2a;
    logic          rs1u, rs2u;
    logic [31:0]   rs1d, rs2d, imm;
    logic [4:0]    rd;
    logic          regwr;
    logic [1:0]    dest;
    logic          memwr;
    logic [AW-1:0] aluop;
  } id_t;

  typedef struct packed {
    logic          valid;
    logic [31:0]   pc, pc4, rs1d, rs2d, imm;
    logic [4:0]    rd;
    logic          regwr;
    logic [1:0]    dest;
    logic          memwr;
    logic [AW-1:0] aluop;
  } ex_t;

  typedef struct {
    ex_t           e;
    bit            full;   // 0: only valid/regwr/memwr are defined
    logic [CW-1:0] cnt;
  } exp_t;

  typedef struct {
    id_t  id;
    logic fl;
    logic sl;
    logic stall;
    exp_t x;
  } stim_t;

  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic id_valid_i = 1'b0, id_rs1_used_i = 1'b0, id_rs2_used_i = 1'b0;
  logic id_reg_wr_sig_i = 1'b0, id_mem_wr_i = 1'b0, flush_i = 1'b0, ex_stall_i = 1'b0;
  logic [31:0] id_pc_i = '0, id_pc_plus4_i = '0, id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [4:0] id_rs1_addr_i = '0, id_rs2_addr_i = '0, id_rd_addr_i = '0;
  logic [1:0] id_data_dest_i = '0;
  logic [AW-1:0] id_alu_op_i = '0;
  logic ex_valid_o, ex_reg_wr_sig_o, ex_mem_wr_o, stall_o;
  logic [31:0] ex_pc_o, ex_pc_plus4_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
  logic [4:0] ex_rd_addr_o;
  logic [1:0] ex_data_dest_o;
  logic [AW-1:0] ex_alu_op_o;
  logic [CW-1:0] bubble_cnt_o;

  exp_t sb[$];
  int vecs = 0;
  int errs = 0;

  id_ex_stage_reg #(.ALU_OP_W(AW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .id_valid_i(id_valid_i), .id_pc_i(id_pc_i), .id_pc_plus4_i(id_pc_plus4_i),
    .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
    .id_rs1_used_i(id_rs1_used_i), .id_rs2_used_i(id_rs2_used_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
    .id_imm_i(id_imm_i), .id_rd_addr_i(id_rd_addr_i), .id_reg_wr_sig_i(id_reg_wr_sig_i),
    .id_data_dest_i(id_data_dest_i), .id_mem_wr_i(id_mem_wr_i), .id_alu_op_i(id_alu_op_i),
    .flush_i(flush_i), .ex_stall_i(ex_stall_i),
    .ex_valid_o(ex_valid_o), .ex_pc_o(ex_pc_o), .ex_pc_plus4_o(ex_pc_plus4_o),
    .ex_rs1_data_o(ex_rs1_data_o), .ex_rs2_data_o(ex_rs2_data_o), .ex_imm_o(ex_imm_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_wr_sig_o(ex_reg_wr_sig_o),
    .ex_data_dest_o(ex_data_dest_o), .ex_mem_wr_o(ex_mem_wr_o), .ex_alu_op_o(ex_alu_op_o),
    .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic id_t mk(logic v, logic [4:0] rs1a, logic rs1u, logic [4:0] rs2a, logic rs2u,
                             logic [4:0] rd, logic regwr, logic [1:0] dest, logic memwr);
    id_t t;
    t.valid = v;
    t.pc    = $urandom & 32'hFFFF_FFFC;
    t.pc4   = t.pc + 32'd4;
    t.rs1a  = rs1a;
    t.rs1u  = rs1u;
    t.rs2a  = rs2a;
    t.rs2u  = rs2u;
    t.rs1d  = $urandom;
    t.rs2d  = $urandom;
    t.imm   = $urandom;
    t.rd    = rd;
    t.regwr = regwr;
    t.dest  = dest;
    t.memwr = memwr;
    t.aluop = AW'($urandom);
    return t;
  endfunction

  // What EX must hold after a normal load of t.
  function automatic ex_t to_ex(id_t t);
    ex_t e;
    e.valid = t.valid;
    e.pc    = t.pc;
    e.pc4   = t.pc4;
    e.rs1d  = t.rs1d;
    e.rs2d  = t.rs2d;
    e.imm   = t.imm;
    e.rd    = t.rd;
    e.regwr = t.regwr & t.valid;
    e.dest  = t.dest;
    e.memwr = t.memwr & t.valid;
    e.aluop = t.aluop;
    return e;
  endfunction

  function automatic ex_t obs();
    ex_t e;
    e.valid = ex_valid_o;
    e.pc    = ex_pc_o;
    e.pc4   = ex_pc_plus4_o;
    e.rs1d  = ex_rs1_data_o;
    e.rs2d  = ex_rs2_data_o;
    e.imm   = ex_imm_o;
    e.rd    = ex_rd_addr_o;
    e.regwr = ex_reg_wr_sig_o;
    e.dest  = ex_data_dest_o;
    e.memwr = ex_mem_wr_o;
    e.aluop = ex_alu_op_o;
    return e;
  endfunction

  function automatic ex_t masked(ex_t x, bit full);
    ex_t m;
    if (full) return x;
    m = '0;
    m.valid = x.valid;
    m.regwr = x.regwr;
    m.memwr = x.memwr;
    return m;
  endfunction

  function automatic exp_t xfull(id_t t, logic [CW-1:0] c);
    exp_t r;
    r.e = to_ex(t);
    r.full = 1'b1;
    r.cnt = c;
    return r;
  endfunction

  function automatic exp_t xbub(logic [CW-1:0] c);
    exp_t r;
    r.e = '0;
    r.full = 1'b0;
    r.cnt = c;
    return r;
  endfunction

  function automatic stim_t mkst(id_t t, logic fl, logic sl, logic stall, exp_t x);
    stim_t s;
    s.id = t;
    s.fl = fl;
    s.sl = sl;
    s.stall = stall;
    s.x = x;
    return s;
  endfunction

  task automatic apply(input id_t t, input logic fl, input logic sl);
    id_valid_i      = t.valid;
    id_pc_i         = t.pc;
    id_pc_plus4_i   = t.pc4;
    id_rs1_addr_i   = t.rs1a;
    id_rs2_addr_i   = t.rs2a;
    id_rs1_used_i   = t.rs1u;
    id_rs2_used_i   = t.rs2u;
    id_rs1_data_i   = t.rs1d;
    id_rs2_data_i   = t.rs2d;
    id_imm_i        = t.imm;
    id_rd_addr_i    = t.rd;
    id_reg_wr_sig_i = t.regwr;
    id_data_dest_i  = t.dest;
    id_mem_wr_i     = t.memwr;
    id_alu_op_i     = t.aluop;
    flush_i         = fl;
    ex_stall_i      = sl;
  endtask

  // Drive one cycle: inputs on the falling edge, sample stall_o, push the
  // expectation, then pop it after the rising edge alongside the DUT state.
  task automatic drive(input stim_t s, output logic st_seen, output ex_t got,
                       output logic [CW-1:0] got_cnt, output exp_t want);
    @(negedge clk_i);
    apply(s.id, s.fl, s.sl);
    #1;
    st_seen = stall_o;
    sb.push_back(s.x);
    @(posedge clk_i);
    #1;
    want    = sb.pop_front();
    got     = obs();
    got_cnt = bubble_cnt_o;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    apply('0, 1'b0, 1'b0);
    rst_n_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_n_i = 1'b1;
  endtask

  task automatic test_reset();
    id_t t;
    exp_t w;
    @(negedge clk_i);
    rst_n_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      t = mk(1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 5'($urandom), 1'b1, 2'($urandom), 1'b1);
      apply(t, 1'($urandom), (i % 2) == 0);
      #1;
      vecs++;
      if ({obs(), bubble_cnt_o, stall_o} !== '0) begin
        errs++;
        $display("FAIL reset_hold[%0d] got ex=%h cnt=%0d stall=%b want all zero", i, obs(), bubble_cnt_o, stall_o);
      end
      @(negedge clk_i);
    end
    t = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, D_ALU, 1'b0);
    t.pc  = 32'h100;
    t.pc4 = 32'h104;
    apply(t, 1'b0, 1'b0);
    rst_n_i = 1'b1;
    #1;
    vecs++;
    if ({obs(), bubble_cnt_o} !== '0) begin
      errs++;
      $display("FAIL reset_release got ex=%h cnt=%0d want zero", obs(), bubble_cnt_o);
    end
    sb.push_back(xfull(t, '0));
    @(posedge clk_i);
    #1;
    w = sb.pop_front();
    vecs++;
    if ({ex_valid_o, ex_pc_o, obs()} !== {1'b1, 32'h100, w.e}) begin
      errs++;
      $display("FAIL reset_first_load got valid=%b pc=%h ex=%h want valid=1 pc=100 ex=%h", ex_valid_o, ex_pc_o, obs(), w.e);
    end
    // Reset asserted between edges while the downstream stall is active.
    @(negedge clk_i);
    apply(mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd4, 1'b1, D_ALU, 1'b0), 1'b0, 1'b1);
    #1;
    vecs++;
    if (stall_o !== 1'b1) begin
      errs++;
      $display("FAIL reset_pre_stall stall_o got %b want 1", stall_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    vecs++;
    if ({obs(), bubble_cnt_o, stall_o} !== '0) begin
      errs++;
      $display("FAIL reset_mid_stall got ex=%h cnt=%0d stall=%b want all zero", obs(), bubble_cnt_o, stall_o);
    end
    @(negedge clk_i);
    apply('0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
  endtask

  task automatic test_load_use();
    stim_t q[$];
    id_t l, d;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    do_reset();
    for (int v = 0; v < 2; v++) begin
      l = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
      d = (v == 0) ? mk(1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, D_ALU, 1'b0)
                   : mk(1'b1, 5'd5, 1'b1, 5'd9, 1'b0, 5'd6, 1'b1, D_ALU, 1'b0);
      q.push_back(mkst(l, 1'b0, 1'b0, 1'b0, xfull(l, CW'(v))));
      q.push_back(mkst(d, 1'b0, 1'b0, 1'b1, xbub(CW'(v + 1))));
      q.push_back(mkst(d, 1'b0, 1'b0, 1'b0, xfull(d, CW'(v + 1))));
    end
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL load_use[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL load_use[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
  endtask

  task automatic test_no_false_hazard();
    stim_t q[$];
    id_t p, d;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: begin
          p = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, D_MEM, 1'b0);
          d = mk(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd8, 1'b1, D_ALU, 1'b0);
        end
        1: begin
          p = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_ALU, 1'b0);
          d = mk(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, D_ALU, 1'b0);
        end
        2: begin
          p = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
          d = mk(1'b1, 5'd5, 1'b0, 5'd3, 1'b1, 5'd8, 1'b1, D_ALU, 1'b0);
        end
        default: begin
          p = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
          d = mk(1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, D_ALU, 1'b1);
        end
      endcase
      q.push_back(mkst(p, 1'b0, 1'b0, 1'b0, xfull(p, '0)));
      q.push_back(mkst(d, 1'b0, 1'b0, 1'b0, xfull(d, '0)));
    end
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL no_hazard[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL no_hazard[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
  endtask

  task automatic test_flush();
    stim_t q[$];
    id_t l, d, st, a;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    do_reset();
    l  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
    d  = mk(1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, D_ALU, 1'b0);
    st = mk(1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 5'd0, 1'b0, D_ALU, 1'b1);
    a  = mk(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd7, 1'b1, D_PC, 1'b1);
    q.push_back(mkst(l,  1'b0, 1'b0, 1'b0, xfull(l, '0)));
    q.push_back(mkst(d,  1'b1, 1'b0, 1'b0, xbub('0)));
    q.push_back(mkst(st, 1'b0, 1'b0, 1'b0, xfull(st, '0)));
    q.push_back(mkst(a,  1'b1, 1'b1, 1'b1, xbub('0)));
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL flush[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL flush[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
  endtask

  task automatic test_ex_stall();
    stim_t q[$];
    id_t a, r1, r2, r3;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    do_reset();
    a  = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
    r1 = mk(1'b1, 5'd5, 1'b0, 5'd5, 1'b0, 5'd9, 1'b1, D_ALU, 1'b1);
    r2 = mk(1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 5'd10, 1'b1, D_PC, 1'b0);
    r3 = mk(1'b1, 5'd6, 1'b1, 5'd7, 1'b1, 5'd11, 1'b1, D_ALU, 1'b1);
    q.push_back(mkst(a,  1'b0, 1'b0, 1'b0, xfull(a, '0)));
    q.push_back(mkst(r1, 1'b0, 1'b1, 1'b1, xfull(a, '0)));
    q.push_back(mkst(r2, 1'b0, 1'b1, 1'b1, xfull(a, '0)));
    q.push_back(mkst(r3, 1'b0, 1'b1, 1'b1, xfull(a, '0)));
    q.push_back(mkst(r3, 1'b0, 1'b0, 1'b0, xfull(r3, '0)));
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL ex_stall[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL ex_stall[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
  endtask

  task automatic test_back_to_back();
    stim_t q[$];
    id_t t;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      t = mk(1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom), 5'($urandom),
             1'($urandom), ($urandom_range(0, 1) == 0) ? D_ALU : D_PC, 1'($urandom));
      q.push_back(mkst(t, 1'b0, 1'b0, 1'b0, xfull(t, '0)));
    end
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL b2b[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL b2b[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
  endtask

  task automatic test_saturation();
    stim_t q[$];
    id_t l, d;
    logic s;
    ex_t g;
    logic [CW-1:0] c;
    exp_t w;
    logic [CW-1:0] want_seq [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    logic [CW-1:0] prev;
    do_reset();
    prev = '0;
    for (int k = 0; k < 5; k++) begin
      l = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
      d = mk(1'b1, 5'd1, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, D_ALU, 1'b0);
      q.push_back(mkst(l, 1'b0, 1'b0, 1'b0, xfull(l, prev)));
      q.push_back(mkst(d, 1'b0, 1'b0, 1'b1, xbub(want_seq[k])));
      q.push_back(mkst(d, 1'b0, 1'b0, 1'b0, xfull(d, want_seq[k])));
      prev = want_seq[k];
    end
    foreach (q[i]) begin
      drive(q[i], s, g, c, w);
      vecs++;
      if (s !== q[i].stall) begin
        errs++;
        $display("FAIL sat[%0d] stall_o got %b want %b", i, s, q[i].stall);
      end
      vecs++;
      if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
        errs++;
        $display("FAIL sat[%0d] ex got %h cnt %0d want %h cnt %0d", i, masked(g, w.full), c, masked(w.e, w.full), w.cnt);
      end
    end
    // Reset asserted while a load-use hazard is pending with a saturated counter.
    q.delete();
    l = mk(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, D_MEM, 1'b0);
    q.push_back(mkst(l, 1'b0, 1'b0, 1'b0, xfull(l, 2'd3)));
    drive(q[0], s, g, c, w);
    vecs++;
    if ({masked(g, w.full), c} !== {masked(w.e, w.full), w.cnt}) begin
      errs++;
      $display("FAIL sat_pre_reset ex got %h cnt %0d want %h cnt %0d", g, c, w.e, w.cnt);
    end
    @(negedge clk_i);
    apply(mk(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, D_ALU, 1'b0), 1'b0, 1'b0);
    #1;
    vecs++;
    if (stall_o !== 1'b1) begin
      errs++;
      $display("FAIL sat_hazard stall_o got %b want 1", stall_o);
    end
    #1 rst_n_i = 1'b0;
    #1;
    vecs++;
    if ({obs(), bubble_cnt_o, stall_o} !== '0) begin
      errs++;
      $display("FAIL reset_mid_bubble got ex=%h cnt=%0d stall=%b want all zero", obs(), bubble_cnt_o, stall_o);
    end
    @(negedge clk_i);
    apply('0, 1'b0, 1'b0);
    rst_n_i = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_flush();
    test_ex_stall();
    test_back_to_back();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- ID/EX pipeline register placed directly downstream of decode; captures the forwarded rs1/rs2 operands and decoded control for the execute stage.
- Owns load-use hazard detection: holds IF/ID and inserts a one-cycle bubble when the instruction in EX is a load whose destination ID needs.
- Also handles branch flush, downstream stall hold, and a saturating bubble performance counter.

Parameters:
- ALU_OP_W, 4, width of the ALU operation field.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_n_i  in  1  reset; asynchronous, active-low.
- id_valid_i  in  1  ID holds a valid instruction.
- id_pc_i  in  32  PC of the ID instruction.
- id_pc_plus4_i  in  32  PC+4 of the ID instruction.
- id_rs1_addr_i, id_rs2_addr_i  in  5 each  source register addresses.
- id_rs1_used_i, id_rs2_used_i  in  1 each  instruction actually reads rs1/rs2.
- id_rs1_data_i, id_rs2_data_i  in  32 each  operands after forwarding.
- id_imm_i  in  32  sign-extended immediate.
- id_rd_addr_i  in  5  destination register.
- id_reg_wr_sig_i  in  1  writes rd.
- id_data_dest_i  in  2  writeback source; shared constants ALU / MEM / PC, where MEM means load.
- id_mem_wr_i  in  1  store.
- id_alu_op_i  in  ALU_OP_W  ALU operation.
- flush_i  in  1  branch/jump taken in EX; kill the ID instruction.
- ex_stall_i  in  1  EX/MEM cannot accept; hold this register.
- ex_valid_o, ex_pc_o, ex_pc_plus4_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_rd_addr_o, ex_reg_wr_sig_o, ex_data_dest_o, ex_mem_wr_o, ex_alu_op_o  out  (widths as their inputs)  registered EX-stage copies.
- stall_o  out  1  hold PC and IF/ID this cycle.
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted.

Behaviour:
- Reset (rst_n_i low, asynchronous): every output register is 0, including ex_valid_o, all control fields, all data fields and bubble_cnt_o. stall_o is 0 while in reset.
- Load-use hazard (combinational from current outputs and ID inputs):
  - hazard = ex_valid_o & ex_reg_wr_sig_o & (ex_rd_addr_o != 0) & (ex_data_dest_o == MEM) & id_valid_i & ((id_rs1_used_i & id_rs1_addr_i == ex_rd_addr_o) | (id_rs2_used_i & id_rs2_addr_i == ex_rd_addr_o)).
  - Both operands are checked independently; an rd of x0 never causes a hazard.
- stall_o = ex_stall_i | (hazard & ~flush_i). It is combinational, with no registered delay.
- Next-state priority, highest first:
  1. flush_i: ex_valid_o, ex_reg_wr_sig_o and ex_mem_wr_o go to 0; data fields are don't-care and hold. Flush wins over ex_stall_i and hazard.
  2. ex_stall_i: all outputs hold their value.
  3. hazard: bubble inserted. ex_valid_o, ex_reg_wr_sig_o and ex_mem_wr_o go to 0; bubble_cnt_o increments. The ID instruction stays in ID because stall_o is 1.
  4. Otherwise: all ex_* outputs load from the id_* inputs. If id_valid_i is 0, reg_wr and mem_wr are forced to 0 (bubble, not counted).
- Load-use latency: exactly one bubble per load-use pair. After the bubble, ex_valid_o is 0, so the hazard clears and the dependent instruction enters EX on the next edge. Its operand is then supplied by MEM/WB forwarding into id_rs*_data_i.
- bubble_cnt_o saturates at all-ones; it never wraps.
- Control fields of a killed or bubbled entry are always 0. Downstream must never see reg_wr or mem_wr with ex_valid_o = 0.
- A reset asserted mid-stall or mid-bubble clears everything immediately. The first cycle after reset loads normally.

Test Plan:
- Reset: hold rst_n_i low with random inputs, then release → all outputs 0; first edge with id_valid_i=1, id_pc_i=0x100 → ex_valid_o=1, ex_pc_o=0x100.
- Load-use: EX holds a load to x5 (dest MEM); ID has rs2=x5 with rs2_used=1 → stall_o=1 for one cycle; next EX is a bubble (valid=0, reg_wr=0); the cycle after, the dependent instruction is in EX; bubble_cnt_o=1.
- No false hazard: EX load to x0, or EX ALU-dest write to x5, or ID rs1=x5 with rs1_used=0 → stall_o=0, no bubble, bubble_cnt_o unchanged.
- Flush with hazard: hazard condition true and flush_i=1 in the same cycle → stall_o=0; EX becomes invalid with reg_wr=0 and mem_wr=0; bubble_cnt_o unchanged.
- Downstream stall: ex_stall_i=1 for 3 cycles with changing ID inputs → ex_* outputs unchanged and stall_o=1 throughout; on release, the current ID instruction loads.
- Saturation: with CNT_W=2, force 5 consecutive load-use pairs → bubble_cnt_o sequence 1, 2, 3, 3, 3.
